// File: rtl/ctrl_decode_stage.sv
// ctrl_decode_stage: registered MIPS control decode with stall/flush, load-use bubbles and byte-lane masks
module ctrl_decode_stage #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int ALU_W   = 4,
  parameter int SHAMT_W = 5,
  parameter int CNT_W   = 8,
  localparam int MB     = DATA_W / 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [31:0]        instr,
  input  logic               stall_in,
  input  logic               flush,
  input  logic               ex_mem_read,
  input  logic [REG_AW-1:0]  ex_rt,
  output logic               stall_out,
  output logic               out_valid,
  output logic               reg_write,
  output logic               mem_to_reg,
  output logic               mem_write,
  output logic               branch,
  output logic               branch_ne,
  output logic               reg_dst,
  output logic               illegal,
  output logic [ALU_W-1:0]   alu_control,
  output logic [1:0]         alu_src,
  output logic [SHAMT_W-1:0] shamt,
  output logic [MB-1:0]      mem_read_mask,
  output logic [MB-1:0]      mem_write_mask,
  output logic [REG_AW-1:0]  rs_q,
  output logic [REG_AW-1:0]  rt_q,
  output logic [REG_AW-1:0]  rd_q,
  output logic [CNT_W-1:0]   illegal_count
);
  typedef struct packed {
    logic               valid;
    logic               reg_write;
    logic               mem_to_reg;
    logic               mem_write;
    logic               branch;
    logic               branch_ne;
    logic               reg_dst;
    logic               illegal;
    logic [ALU_W-1:0]   alu;
    logic [1:0]         src;
    logic [SHAMT_W-1:0] sh;
    logic [MB-1:0]      rmask;
    logic [MB-1:0]      wmask;
  } ctrl_t;
  localparam logic [ALU_W-1:0] ADD = ALU_W'(0), SUB = ALU_W'(1), AND = ALU_W'(2), OR = ALU_W'(3),
    XOR = ALU_W'(4), NOR = ALU_W'(5), SLL = ALU_W'(6), SRL = ALU_W'(7), SRA = ALU_W'(8), SLT = ALU_W'(9);
  logic [5:0] op, funct;
  logic [REG_AW-1:0] rs, rt, rd;
  logic haz, kill, load;
  ctrl_t d, q;
  assign op    = instr[31:26];
  assign funct = instr[5:0];
  assign rs    = REG_AW'(instr[25:21]);
  assign rt    = REG_AW'(instr[20:16]);
  assign rd    = REG_AW'(instr[15:11]);
  assign haz       = in_valid & ex_mem_read & (ex_rt != '0) & ((ex_rt == rs) | (ex_rt == rt));
  assign stall_out = stall_in | (haz & ~flush);
  assign kill      = flush | haz;
  assign load      = flush | ~stall_in;
  always_comb begin
    d = '0;
    d.valid = 1'b1;
    case (op)
      6'b000000: begin
        d.reg_write = 1'b1;
        d.reg_dst   = 1'b1;
        case (funct)
          6'b100000: d.alu = ADD;
          6'b100010: d.alu = SUB;
          6'b100100: d.alu = AND;
          6'b100101: d.alu = OR;
          6'b100110: d.alu = XOR;
          6'b100111: d.alu = NOR;
          6'b101010: d.alu = SLT;
          6'b000000: d.alu = SLL;
          6'b000010: d.alu = SRL;
          6'b000011: d.alu = SRA;
          6'b000100: d.alu = SLL;
          6'b000110: d.alu = SRL;
          6'b000111: d.alu = SRA;
          default:   d = '{valid: 1'b1, illegal: 1'b1, default: '0};
        endcase
        // immediate shifts take their amount from the sh field
        if (!d.illegal && (funct == 6'b000000 || funct == 6'b000010 || funct == 6'b000011)) begin
          d.src = 2'b10;
          d.sh  = SHAMT_W'(instr[10:6]);
        end
      end
      6'b001000, 6'b001010, 6'b001100, 6'b001101, 6'b001110: begin
        d.reg_write = 1'b1;
        d.src       = 2'b01;
        d.alu       = op == 6'b001010 ? SLT : op == 6'b001100 ? AND : op == 6'b001101 ? OR :
                      op == 6'b001110 ? XOR : ADD;
      end
      6'b001111: begin
        d.reg_write = 1'b1;
        d.src       = 2'b01;
        d.alu       = SLL;
        d.sh        = SHAMT_W'(16);
      end
      6'b100011, 6'b100111, 6'b100000, 6'b100100, 6'b100001, 6'b100101: begin
        d.reg_write  = 1'b1;
        d.mem_to_reg = 1'b1;
        d.src        = 2'b01;
        d.rmask      = op[1] ? '1 : op[0] ? MB'(3) : MB'(1);
      end
      6'b101011, 6'b101000, 6'b101001: begin
        d.mem_write = 1'b1;
        d.src       = 2'b01;
        d.wmask     = op[1] ? '1 : op[0] ? MB'(3) : MB'(1);
      end
      6'b000100, 6'b000101: begin
        d.branch    = 1'b1;
        d.branch_ne = op[0];
        d.alu       = SUB;
      end
      default: d = '{valid: 1'b1, illegal: 1'b1, default: '0};
    endcase
    if (!in_valid) d = '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      q             <= '0;
      rs_q          <= '0;
      rt_q          <= '0;
      rd_q          <= '0;
      illegal_count <= '0;
    end else if (load) begin
      q    <= kill ? '0 : d;
      rs_q <= rs;
      rt_q <= rt;
      rd_q <= rd;
      if (!kill && d.illegal && illegal_count != '1) illegal_count <= illegal_count + 1'b1;
    end
  end
  assign out_valid      = q.valid;
  assign reg_write      = q.reg_write;
  assign mem_to_reg     = q.mem_to_reg;
  assign mem_write      = q.mem_write;
  assign branch         = q.branch;
  assign branch_ne      = q.branch_ne;
  assign reg_dst        = q.reg_dst;
  assign illegal        = q.illegal;
  assign alu_control    = q.alu;
  assign alu_src        = q.src;
  assign shamt          = q.sh;
  assign mem_read_mask  = q.rmask;
  assign mem_write_mask = q.wmask;
endmodule

// File: tb/tb_ctrl_decode_stage.sv
// tb_ctrl_decode_stage: directed vectors with hand-computed expectations for ctrl_decode_stage
module tb_ctrl_decode_stage;
  logic clk = 0, rst = 1, in_valid = 0, stall_in = 0, flush = 0, ex_mem_read = 0;
  logic [31:0] instr = '0;
  logic [4:0] ex_rt = '0;
  logic stall_out, out_valid, reg_write, mem_to_reg, mem_write, branch, branch_ne, reg_dst, illegal;
  logic [3:0] alu_control, mem_read_mask, mem_write_mask;
  logic [1:0] alu_src;
  logic [4:0] shamt, rs_q, rt_q, rd_q;
  logic [7:0] illegal_count;
  int checks = 0, errors = 0;
  localparam logic [31:0] I_ADD = 32'h00221820, I_LUI = 32'h3C051234, I_SH = 32'hA4220004,
    I_LB = 32'h80220000, I_SRA = 32'h00021903, I_SW = 32'hAC220000, I_BNE = 32'h14220008,
    I_BAD = 32'hFC000000, I_BADR = 32'h0000003F;
  ctrl_decode_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .instr(instr), .stall_in(stall_in), .flush(flush),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .stall_out(stall_out), .out_valid(out_valid),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .mem_write(mem_write), .branch(branch),
    .branch_ne(branch_ne), .reg_dst(reg_dst), .illegal(illegal), .alu_control(alu_control),
    .alu_src(alu_src), .shamt(shamt), .mem_read_mask(mem_read_mask), .mem_write_mask(mem_write_mask),
    .rs_q(rs_q), .rt_q(rt_q), .rd_q(rd_q), .illegal_count(illegal_count)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [31:0] ins);
    in_valid = 1;
    instr = ins;
    tick();
  endtask
  initial begin
    stall_in = 1;
    tick();
    tick();
    check("rst_stall_out", stall_out, 1);
    check("rst_valid", out_valid, 0);
    check("rst_alu", alu_control, 0);
    check("rst_masks", {mem_read_mask, mem_write_mask}, 0);
    check("rst_cnt", illegal_count, 0);
    check("rst_rs", rs_q, 0);
    rst = 0;
    stall_in = 0;
    issue(I_ADD);
    check("add_valid", out_valid, 1);
    check("add_ctl", {reg_write, reg_dst, mem_to_reg, mem_write}, 4'b1100);
    check("add_alu", alu_control, 0);
    check("add_src", alu_src, 0);
    check("add_regs", {rs_q, rt_q, rd_q}, {5'd1, 5'd2, 5'd3});
    issue(I_LUI);
    check("lui_alu", alu_control, 6);
    check("lui_shamt", shamt, 16);
    check("lui_src", alu_src, 1);
    check("lui_rw", {reg_write, reg_dst}, 2'b10);
    issue(I_SH);
    check("sh_wmask", mem_write_mask, 4'h3);
    check("sh_ctl", {mem_write, reg_write, mem_to_reg}, 3'b100);
    check("sh_rmask", mem_read_mask, 0);
    issue(I_LB);
    check("lb_rmask", mem_read_mask, 4'h1);
    check("lb_ctl", {mem_to_reg, reg_write, mem_write}, 3'b110);
    issue(I_SRA);
    check("sra", {alu_control, alu_src, shamt}, {4'd8, 2'd2, 5'd4});
    ex_mem_read = 1;
    ex_rt = 2;
    instr = I_ADD;
    #1;
    check("haz_stall", stall_out, 1);
    flush = 1;
    #1;
    check("haz_flush_nostall", stall_out, 0);
    flush = 0;
    tick();
    check("haz_bubble", {out_valid, reg_write, reg_dst}, 0);
    check("haz_addr", rd_q, 3);
    ex_mem_read = 0;
    tick();
    check("haz_after", {out_valid, reg_write}, 2'b11);
    ex_mem_read = 1;
    ex_rt = 0;
    #1;
    check("haz_r0", stall_out, 0);
    tick();
    check("haz_r0_valid", out_valid, 1);
    ex_mem_read = 0;
    issue(I_SW);
    check("sw_wmask", mem_write_mask, 4'hF);
    stall_in = 1;
    instr = I_LB;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold", {out_valid, mem_write, mem_write_mask, mem_read_mask}, {2'b11, 4'hF, 4'h0});
    end
    flush = 1;
    tick();
    check("stall_flush", {out_valid, mem_write}, 0);
    stall_in = 0;
    flush = 0;
    issue(I_BNE);
    check("bne", {out_valid, branch, branch_ne, alu_control}, {3'b111, 4'd1});
    flush = 1;
    tick();
    check("bne_flush", {out_valid, branch}, 0);
    flush = 0;
    in_valid = 0;
    tick();
    check("idle", {out_valid, reg_write}, 0);
    issue(I_BADR);
    check("badr", {out_valid, illegal, reg_write, reg_dst}, 4'b1100);
    check("badr_cnt", illegal_count, 1);
    flush = 1;
    instr = I_BAD;
    tick();
    check("flush_cnt", {illegal, illegal_count}, {1'b0, 8'd1});
    flush = 0;
    for (int k = 1; k <= 300; k++) begin
      issue(I_BAD);
      if (k == 100) check("cnt_100", illegal_count, 101);
    end
    check("sat", {illegal, out_valid, illegal_count}, {2'b11, 8'd255});
    stall_in = 1;
    rst = 1;
    tick();
    check("rst_mid_stall", {out_valid, illegal, illegal_count}, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ctrl_decode_stage.md
# ctrl_decode_stage

Registered, parametrised successor to the single-cycle control decoder: decodes a full MIPS instruction word into the ID/EX control bundle, one instruction per cycle, with a valid/stall/flush pipeline register, load-use hazard detection with bubble insertion, and generalised byte-lane masks. It sits between the IF/ID register and the execute stage; the ALU, memory byte-masking unit and writeback mux consume its outputs directly.

## Interface
- DATA_W, 32, datapath width; must be a multiple of 8; byte-mask width MB = DATA_W/8.
- REG_AW, 5, register-address width.
- ALU_W, 4, ALU control width; must be at least 4.
- SHAMT_W, 5, shift-amount width.
- CNT_W, 8, width of the saturating illegal-instruction counter.

- clk  in  1  rising-edge clock; single clock domain.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  instr holds a real instruction.
- instr  in  32  instruction word: op[31:26], rs[25:21], rt[20:16], rd[15:11], sh[10:6], funct[5:0].
- stall_in  in  1  downstream stall; hold the output register.
- flush  in  1  branch taken; kill the current decode.
- ex_mem_read  in  1  the instruction now in EX is a load.
- ex_rt  in  REG_AW  destination of that load.
- stall_out  out  1  combinational; freezes PC and IF/ID.
- out_valid, reg_write, mem_to_reg, mem_write, branch, branch_ne, reg_dst, illegal  out  1 each  registered control bits.
- alu_control  out  ALU_W  ADD 0, SUB 1, AND 2, OR 3, XOR 4, NOR 5, SLL 6, SRL 7, SRA 8, SLT 9; zero-extended to ALU_W.
- alu_src  out  2  00 register B, 01 immediate, 10 shamt field.
- shamt  out  SHAMT_W  shift amount for the ALU.
- mem_read_mask, mem_write_mask  out  MB  active byte lanes, bit 0 = least significant byte.
- rs_q, rt_q, rd_q  out  REG_AW each  registered register addresses.
- illegal_count  out  CNT_W  saturating count of illegal instructions accepted.

## Operation
- R-type (op 000000), funct mapping:
  - 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 101010 SLT: alu_src 00.
  - 000000 SLL, 000010 SRL, 000011 SRA: alu_src 10, shamt = sh.
  - 000100 SLLV, 000110 SRLV, 000111 SRAV: alu_src 00.
  - All of these: reg_write 1, reg_dst 1.
- I-type: 001000 ADDI, 001010 SLTI, 001100 ANDI, 001101 ORI, 001110 XORI: reg_write 1, alu_src 01, reg_dst 0.
- 001111 LUI: reg_write 1, alu_src 01, alu_control SLL, shamt 16.
- Loads (alu_src 01, ADD, reg_write 1, mem_to_reg 1):
  - LW/LWU 100011/100111: read mask all ones.
  - LB/LBU 100000/100100: read mask 1.
  - LH/LHU 100001/100101: read mask 3.
- Stores (alu_src 01, ADD, mem_write 1):
  - SW 101011: write mask all ones.
  - SB 101000: write mask 1.
  - SH 101001: write mask 3.
- BEQ 000100 and BNE 000101: branch 1, ALU SUB, alu_src 00; BNE additionally sets branch_ne 1.
- Inactive masks are zero. mem_write is 1 only for stores; mem_to_reg is 1 only for loads.
- Any other op or funct is illegal: out_valid 1, illegal 1, every enable 0, illegal_count += 1, saturating at all ones.
- Hazard: haz = in_valid & ex_mem_read & (ex_rt != 0) & (ex_rt == rs | ex_rt == rt).
- stall_out = stall_in | (haz & ~flush).
- Register update priority, highest first:
  - rst: clear.
  - flush: load a bubble.
  - stall_in: hold.
  - haz: load a bubble.
  - otherwise: load the decode; out_valid = in_valid.
- Bubble: out_valid 0 and all control bits, masks, alu_src, shamt and alu_control 0. Address fields load normally.
- in_valid 0 also produces bubble control values.

## Timing
- Latency 1 cycle from instr to the registered outputs; throughput 1 instruction per cycle.
- Reset: every registered output 0, including masks, alu_control and illegal_count. stall_out reflects its inputs even during reset.
- rst asserted mid-stall takes priority and clears the register on that edge.
- flush together with stall_in: the bubble is loaded; flush wins.
- A load-use hazard yields exactly one bubble, provided the EX load advances on the next cycle.
- illegal_count increments only when an illegal decode is actually loaded, never on hold, flush or bubble.

## Test plan
- Reset: after rst, all outputs are 0. ADD r3,r1,r2 (0x00221820) -> next cycle out_valid 1, reg_write 1, reg_dst 1, alu_control 0, alu_src 00.
- LUI r5,0x1234 -> alu_control 6, shamt 16, alu_src 01, reg_write 1. SH -> write mask 0x3, mem_write 1. LB -> read mask 0x1, mem_to_reg 1.
- ex_mem_read 1, ex_rt 2, decode ADD using r2 -> stall_out 1 that cycle, bubble registered. With ex_rt 0 -> no stall.
- stall_in held 3 cycles -> outputs frozen. stall_in together with flush -> bubble loaded.
- op 111111 issued 300 times with CNT_W 8 -> illegal 1 each time, illegal_count saturates at 255.
- BNE -> branch 1, branch_ne 1, alu_control 1. A flush on the same cycle -> out_valid 0 next cycle.
